// File: rtl/arm_dp_sequencer.sv
// Multi-cycle sequencer for ARM data-processing instructions: fetches a little-endian
// word one byte at a time, decodes it once, and drives the ALU and register file for one cycle.
module arm_dp_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  mem_data,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [3:0]  alu_flags,
  output logic [4:0]  alu_op,
  output logic        alu_s,
  output logic        alu_out_en,
  output logic [3:0]  rn_sel,
  output logic [3:0]  rd_sel,
  output logic [3:0]  rm_sel,
  output logic        rf_we,
  output logic        imm_en,
  output logic [31:0] imm_val,
  output logic [3:0]  cpsr_flags,
  output logic        instr_done,
  output logic        undef
);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] pc;
  logic [23:0] instr_lo;
  logic        go_exec;
  logic        dec_s;
  logic        dec_we;

  logic [31:0] word;
  logic [3:0]  op;
  logic        writes_rd;
  logic        legal;
  logic        pass;
  logic [31:0] imm32;
  logic [63:0] imm_dbl;
  logic [31:0] imm_rot;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return c;
      4'h3:    return !c;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return c && !z;
      4'h9:    return !c || z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Decode works on the word as it completes, so DECODE-cycle outputs come straight from registers.
  always_comb begin
    word      = {mem_data, instr_lo};
    op        = word[24:21];
    writes_rd = (op[3:2] != 2'b10);
    legal     = (word[27:26] == 2'b00) && (word[31:28] != 4'hF)
                && (word[25] || (word[11:4] == 8'h00))
                && (writes_rd ? (word[15:12] != 4'hF) : word[20]);
    pass      = cond_pass(word[31:28], cpsr_flags);
    imm32     = {24'h000000, word[7:0]};
    imm_dbl   = {imm32, imm32} >> {word[11:8], 1'b0};
    imm_rot   = imm_dbl[31:0];
  end

  assign mem_req  = rst_n && (state == FETCH);
  assign mem_addr = pc + {30'b0, cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      cnt        <= '0;
      pc         <= '0;
      instr_lo   <= '0;
      go_exec    <= 1'b0;
      dec_s      <= 1'b0;
      dec_we     <= 1'b0;
      alu_op     <= '0;
      alu_s      <= 1'b0;
      alu_out_en <= 1'b0;
      rn_sel     <= '0;
      rd_sel     <= '0;
      rm_sel     <= '0;
      rf_we      <= 1'b0;
      imm_en     <= 1'b0;
      imm_val    <= '0;
      cpsr_flags <= '0;
      instr_done <= 1'b0;
      undef      <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            cnt <= cnt + 2'd1;
            case (cnt)
              2'd0: instr_lo[7:0]   <= mem_data;
              2'd1: instr_lo[15:8]  <= mem_data;
              2'd2: instr_lo[23:16] <= mem_data;
              default: begin
                state      <= DECODE;
                alu_op     <= (op == 4'b1101) ? 5'b10000 : {1'b0, op};
                rn_sel     <= word[19:16];
                rd_sel     <= word[15:12];
                rm_sel     <= word[3:0];
                imm_en     <= word[25];
                imm_val    <= word[25] ? imm_rot : '0;
                go_exec    <= legal && pass;
                dec_s      <= word[20];
                dec_we     <= writes_rd;
                instr_done <= !(legal && pass);
                undef      <= !legal;
              end
            endcase
          end
        end
        DECODE: begin
          undef <= 1'b0;
          if (go_exec) begin
            state      <= EXEC;
            alu_out_en <= 1'b1;
            alu_s      <= dec_s;
            rf_we      <= dec_we;
            instr_done <= 1'b1;
          end else begin
            // Skipped or undefined: step over the word without touching ALU or register file.
            state      <= FETCH;
            pc         <= pc + 32'd4;
            instr_done <= 1'b0;
            alu_op     <= '0;
            rn_sel     <= '0;
            rd_sel     <= '0;
            rm_sel     <= '0;
            imm_en     <= 1'b0;
            imm_val    <= '0;
          end
        end
        EXEC: begin
          if (alu_s)
            cpsr_flags <= alu_flags;
          state      <= FETCH;
          pc         <= pc + 32'd4;
          alu_op     <= '0;
          alu_s      <= 1'b0;
          alu_out_en <= 1'b0;
          rn_sel     <= '0;
          rd_sel     <= '0;
          rm_sel     <= '0;
          rf_we      <= 1'b0;
          imm_en     <= 1'b0;
          imm_val    <= '0;
          instr_done <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_dp_sequencer.sv
// Self-checking bench for arm_dp_sequencer: directed encodings plus random instructions
// and memory stalls, compared against an instruction-level reference model.
module tb_arm_dp_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  alu_flags;
  logic [4:0]  alu_op;
  logic        alu_s;
  logic        alu_out_en;
  logic [3:0]  rn_sel;
  logic [3:0]  rd_sel;
  logic [3:0]  rm_sel;
  logic        rf_we;
  logic        imm_en;
  logic [31:0] imm_val;
  logic [3:0]  cpsr_flags;
  logic        instr_done;
  logic        undef;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] pc_m;
  logic [3:0]  cpsr_m;

  arm_dp_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .alu_flags  (alu_flags),
    .alu_op     (alu_op),
    .alu_s      (alu_s),
    .alu_out_en (alu_out_en),
    .rn_sel     (rn_sel),
    .rd_sel     (rd_sel),
    .rm_sel     (rm_sel),
    .rf_we      (rf_we),
    .imm_en     (imm_en),
    .imm_val    (imm_val),
    .cpsr_flags (cpsr_flags),
    .instr_done (instr_done),
    .undef      (undef)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (pc_m=%0h t=%0t)", tag, got, exp, pc_m, $time);
    end
  endtask

  // Architectural condition test from the named ARM conditions.
  function automatic logic model_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'd0:  return z == 1'b1;
      4'd1:  return z == 1'b0;
      4'd2:  return c == 1'b1;
      4'd3:  return c == 1'b0;
      4'd4:  return n == 1'b1;
      4'd5:  return n == 1'b0;
      4'd6:  return v == 1'b1;
      4'd7:  return v == 1'b0;
      4'd8:  return (c == 1'b1) && (z == 1'b0);
      4'd9:  return (c == 1'b0) || (z == 1'b1);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return (z == 1'b0) && (n == v);
      4'd13: return (z == 1'b1) || (n != v);
      default: return cond == 4'd14;
    endcase
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] w);
    logic [31:0] v;
    v = {24'h0, w[7:0]};
    for (int k = 0; k < 2 * int'(w[11:8]); k++)
      v = {v[0], v[31:1]};
    return v;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) < 2) return w;
    w[27:26] = 2'b00;
    w[31:28] = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    if (!w[25]) w[11:4] = 8'h00;
    if (w[24:23] == 2'b10) w[20] = 1'b1;
    else if (w[15:12] == 4'hF) w[15:12] = 4'($urandom_range(0, 14));
    return w;
  endfunction

  task automatic run_instr(input logic [31:0] w, input logic [3:0] fl,
                           input int stall_at, input int stall_len, input bit rnd);
    logic [3:0]  op;
    logic        writes, legal, pass;
    logic [4:0]  exp_op;
    logic [31:0] exp_imm;
    op      = w[24:21];
    writes  = !(op >= 4'd8 && op <= 4'd11);
    legal   = (w[27:26] == 2'b00) && (w[31:28] != 4'hF) && (w[25] || w[11:4] == 8'h00)
              && (writes ? (w[15:12] != 4'd15) : (w[20] == 1'b1));
    pass    = model_cond(w[31:28], cpsr_m);
    exp_op  = (op == 4'd13) ? 5'd16 : {1'b0, op};
    exp_imm = w[25] ? model_imm(w) : 32'h0;

    for (int i = 0; i < 4; i++) begin
      int n;
      n = (i == stall_at) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < n; s++) begin
        mem_ready = 1'b0;
        mem_data  = 8'($urandom);
        check("stall_req", mem_req, 1);
        check("stall_addr", mem_addr, pc_m + 32'(i));
        @(negedge clk);
      end
      check("fetch_req", mem_req, 1);
      check("fetch_addr", mem_addr, pc_m + 32'(i));
      check("fetch_we", rf_we, 0);
      mem_ready = 1'b1;
      mem_data  = w[8*i +: 8];
      @(negedge clk);
    end
    mem_ready = 1'b0;
    alu_flags = fl;

    check("dec_req", mem_req, 0);
    check("dec_undef", undef, !legal);
    check("dec_done", instr_done, !(legal && pass));
    check("dec_out_en", alu_out_en, 0);
    check("dec_we", rf_we, 0);
    if (legal) begin
      check("dec_op", alu_op, exp_op);
      check("dec_sel", {rn_sel, rd_sel, rm_sel}, {w[19:16], w[15:12], w[3:0]});
      check("dec_imm_en", imm_en, w[25]);
      check("dec_imm", imm_val, exp_imm);
    end
    @(negedge clk);

    if (legal && pass) begin
      check("ex_req", mem_req, 0);
      check("ex_out_en", alu_out_en, 1);
      check("ex_s", alu_s, w[20]);
      check("ex_we", rf_we, writes);
      check("ex_done", instr_done, 1);
      check("ex_undef", undef, 0);
      check("ex_op", alu_op, exp_op);
      check("ex_sel", {rn_sel, rd_sel, rm_sel}, {w[19:16], w[15:12], w[3:0]});
      check("ex_imm", imm_val, exp_imm);
      @(negedge clk);
      if (w[20]) cpsr_m = fl;
    end
    pc_m = pc_m + 32'd4;

    check("nx_req", mem_req, 1);
    check("nx_addr", mem_addr, pc_m);
    check("nx_cpsr", cpsr_flags, cpsr_m);
    check("nx_done", instr_done, 0);
    check("nx_idle", {alu_out_en, rf_we, undef, alu_s, imm_en}, 0);
    check("nx_op", alu_op, 0);
    check("nx_imm", imm_val, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_cpsr"}, cpsr_flags, 0);
    check({tag, "_imm"}, imm_val, 0);
    check({tag, "_ctl"}, {alu_op, alu_s, alu_out_en, rn_sel, rd_sel, rm_sel,
                          rf_we, imm_en, instr_done, undef}, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_data  = 8'h00;
    mem_ready = 1'b0;
    alu_flags = 4'h0;
    pc_m      = 32'h0;
    cpsr_m    = 4'h0;
    #3;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_req", mem_req, 1);
    check("rel_addr", mem_addr, 0);

    run_instr(32'hE2800001, 4'hF, 2, 3, 1'b0);   // ADD r0,r0,#1 with stall at byte 2
    run_instr(32'h03A00005, 4'hF, -1, 0, 1'b0);  // MOVEQ with Z=0: skipped
    run_instr(32'hE3A014FF, 4'h0, -1, 0, 1'b0);  // MOV r1,#0xFF000000
    run_instr(32'hEA000000, 4'h0, -1, 0, 1'b0);  // branch: undefined here
    run_instr(32'hE35100FF, 4'b0110, -1, 0, 1'b0); // CMP r1,#0xFF
    run_instr(32'h03A00005, 4'hF, -1, 0, 1'b0);  // MOVEQ now passes (Z=1)

    for (int k = 0; k < 200; k++)
      run_instr(gen_instr(), 4'($urandom), -1, 0, 1'b1);

    // Ensure flags are nonzero, then reset in the middle of the third byte fetch.
    run_instr(32'hE35100FF, 4'b1001, -1, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b1;
      mem_data  = 8'hA5;
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    pc_m   = 32'h0;
    cpsr_m = 4'h0;
    #1;
    check("arel_req", mem_req, 1);
    check("arel_addr", mem_addr, 0);
    check("arel_cpsr", cpsr_flags, 0);

    for (int k = 0; k < 20; k++)
      run_instr(gen_instr(), 4'($urandom), -1, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
